mmac_operand_loader: RTL and testbench
======================================

Name: mmac_operand_loader

Overview:
Producer-side front end for the matrix MAC unit. It accepts a serial stream of matrix elements over a valid/ready handshake and assembles operand A, then operand B, into the packed flat vectors the MAC consumes. It then presents the packed pair with a valid/ready handshake. The block sits between the element source (DMA/host FIFO) and the MAC unit's matrixA/matrixB inputs.

Parameters:
M_SIZE, 4, matrix dimension (square M_SIZE x M_SIZE); mirrors mmac_pkg::M_SIZE
VAR_WIDTH, 8, element width in bits; mirrors mmac_pkg::VAR_WIDTH
MAT_WIDTH, M_SIZE*M_SIZE*VAR_WIDTH (128), packed matrix width; derived, not overridden

Ports:
clock      input   1          clock, all logic on rising edge
reset      input   1          synchronous, active-low reset
clear      input   1          synchronous flush, active-high
in_valid   input   1          element stream valid
in_ready   output  1          element stream ready
in_data    input   VAR_WIDTH  element value
in_last    input   1          marks final element of an A+B frame (element 2*M_SIZE*M_SIZE-1)
out_valid  output  1          packed operand pair valid
out_ready  input   1          MAC side accepts pair
matrix_a   output  MAT_WIDTH  packed operand A
matrix_b   output  MAT_WIDTH  packed operand B
err_len    output  1          sticky frame-length error

Behaviour:
- Reset: reset and clock as decided: reset is synchronous, active-low; clock is clock. While reset is low on a rising edge: state=LOAD_A, idx=0, matrix_a=0, matrix_b=0, out_valid=0, err_len=0. in_ready=0 while reset is low.
- Element transfer occurs on in_valid && in_ready at the rising edge. Pair transfer occurs on out_valid && out_ready.
- Packing: element (r,c) occupies bits [(N*N-1-(r*N+c))*VAR_WIDTH +: VAR_WIDTH], where N=M_SIZE. Element (0,0) sits in the MSBs. Stream order is row-major: idx = r*N+c.
- FSM states:
  - LOAD_A: in_ready=1. Each transfer writes in_data to slot idx of matrix_a, then idx++. At idx=N*N-1, the transfer sets idx=0 and moves to LOAD_B.
  - LOAD_B: in_ready=1. Same as LOAD_A into matrix_b. At idx=N*N-1, the transfer moves to PRESENT.
  - PRESENT: in_ready=0, out_valid=1. On out_ready, the next state is LOAD_A, out_valid drops and idx=0.
- Latency: out_valid rises on the first edge after the final B element is accepted. There is no bubble: in_ready is 1 in the cycle after the pair is accepted.
- Operand stability: matrix_a and matrix_b are held stable throughout PRESENT. They keep their last values outside PRESENT, except for slots being overwritten. Consumers sample them only under out_valid.
- Length check on in_last:
  - in_last=1 on a transfer before global element 2N*N-1: the frame is discarded. Next state is LOAD_A, idx=0, err_len=1, and matrix contents are left as is.
  - in_last=0 on the final transfer: the frame is accepted normally and err_len=1.
- err_len is cleared only by reset or clear.
- clear=1: same effect as reset on state, idx, out_valid and err_len. matrix_a and matrix_b are zeroed. clear has priority over any simultaneous handshake.
- in_valid without in_ready is ignored; in_data is not sampled.

Optional Feature:
MMAC_LOADER_TRANSPOSE_B_EN.
- Defined: B elements are streamed column-major. Stream index idx maps to (r,c) = (idx%N, idx/N). Packing of matrix_b is unchanged, so the source can supply B^T memory order.
- Undefined: B is row-major, identical to A.
- A is always row-major.

Decomposition:
- mmac_pkg receives:
  - the loader_state_e enum (LOAD_A, LOAD_B, PRESENT)
  - the MAT_WIDTH localparam
  - the function slot_lsb(r,c), returning the bit offset of element (r,c), shared with the MAC and the bench
- One sub-module, mmac_elem_packer, is natural. It holds one MAT_WIDTH register with an indexed element write and a clear, and is instantiated twice (A and B).

Test Plan:
1. Stream A=1..16 and B=17..32 (in_last on the 32nd), out_ready=1 -> out_valid for exactly 1 cycle, one edge after the 32nd transfer. matrix_a[127:120]=1, matrix_a[7:0]=16, matrix_b[127:120]=17, err_len=0.
2. Same stream with out_ready=0 for 5 cycles, then 1 -> out_valid held 6 cycles with operands stable. in_ready=0 throughout. in_ready=1 on the cycle after acceptance.
3. Random in_valid gaps (50%) during loading -> same packed result as case 1. No element is taken while in_valid=0.
4. in_last on element 10 -> no out_valid, err_len=1. The following clean 32-element frame produces a correct pair.
5. clear asserted mid-B (element 20) -> state LOAD_A, matrices 0, err_len 0. A full new frame of all 8'hFF yields matrix_a=matrix_b=128'hFF..FF.
6. With MMAC_LOADER_TRANSPOSE_B_EN, B stream 17..32 -> matrix_b element (1,0)=18 and (0,1)=21.

Source files
------------

// File: rtl/mmac_pkg.sv
// Shared MAC definitions: matrix geometry, loader FSM states and element packing offset.
package mmac_pkg;
    localparam int M_SIZE    = 4;
    localparam int VAR_WIDTH = 8;
    localparam int N_ELEMS   = M_SIZE * M_SIZE;
    localparam int MAT_WIDTH = N_ELEMS * VAR_WIDTH;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        PRESENT
    } loader_state_e;

    // Element (0,0) occupies the MSBs of the packed matrix; row-major toward the LSBs.
    function automatic int unsigned slot_lsb(input int unsigned r, input int unsigned c);
        return (N_ELEMS - 1 - (r * M_SIZE + c)) * VAR_WIDTH;
    endfunction
endpackage

// File: rtl/mmac_operand_loader_if.sv
// Element stream in, packed operand pair out. slave = loader side, master = source/MAC side.
interface mmac_operand_loader_if #(
    parameter int VAR_WIDTH = 8,
    parameter int MAT_WIDTH = 128
);
    logic                 in_valid;
    logic                 in_ready;
    logic [VAR_WIDTH-1:0] in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [MAT_WIDTH-1:0] matrix_a;
    logic [MAT_WIDTH-1:0] matrix_b;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, matrix_a, matrix_b
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, matrix_a, matrix_b
    );
endinterface

// File: rtl/mmac_elem_packer.sv
// One packed matrix register with a single indexed element write per cycle.
module mmac_elem_packer #(
    parameter int N_ELEMS   = 16,
    parameter int VAR_WIDTH = 8,
    parameter int IDX_W     = $clog2(N_ELEMS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         we,
    input  logic [IDX_W-1:0]             slot,
    input  logic [VAR_WIDTH-1:0]         data,
    output logic [N_ELEMS*VAR_WIDTH-1:0] mat
);
    genvar gi;
    generate
        for (gi = 0; gi < N_ELEMS; gi++) begin : g_slot
            logic [VAR_WIDTH-1:0] elem_reg;

            always_ff @(posedge clock) begin
                if (!reset || clear) begin
                    elem_reg <= '0;
                end else if (we && slot == IDX_W'(gi)) begin
                    elem_reg <= data;
                end
            end

            assign mat[(N_ELEMS-1-gi)*VAR_WIDTH +: VAR_WIDTH] = elem_reg;
        end
    endgenerate
endmodule

// File: rtl/mmac_operand_loader.sv
// Assembles a serial A-then-B element stream into packed MAC operands.
// Optional: define MMAC_LOADER_TRANSPOSE_B_EN to accept B in column-major stream order.
module mmac_operand_loader
    import mmac_pkg::*;
#(
    parameter int M_SIZE    = mmac_pkg::M_SIZE,
    parameter int VAR_WIDTH = mmac_pkg::VAR_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    mmac_operand_loader_if.slave    bus,
    output logic                    err_len
);
    localparam int N_ELEMS   = M_SIZE * M_SIZE;
    localparam int MAT_WIDTH = N_ELEMS * VAR_WIDTH;
    localparam int IDX_W     = $clog2(N_ELEMS);

    loader_state_e        state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 err_len_reg, err_len_next;
    logic                 in_ready_int, xfer, last_pos, early_last;
    logic                 we_a, we_b;
    logic [IDX_W-1:0]     b_slot;
    logic [MAT_WIDTH-1:0] mat_a, mat_b;

    assign in_ready_int = reset && (state_reg == LOAD_A || state_reg == LOAD_B);
    assign xfer         = bus.in_valid && in_ready_int;
    assign last_pos     = (idx_reg == IDX_W'(N_ELEMS - 1));
    // in_last anywhere except the final B element truncates the frame.
    assign early_last   = bus.in_last && !(state_reg == LOAD_B && last_pos);
    assign we_a         = xfer && (state_reg == LOAD_A) && !early_last;
    assign we_b         = xfer && (state_reg == LOAD_B) && !early_last;

`ifdef MMAC_LOADER_TRANSPOSE_B_EN
    assign b_slot = IDX_W'((int'(idx_reg) % M_SIZE) * M_SIZE + int'(idx_reg) / M_SIZE);
`else
    assign b_slot = idx_reg;
`endif

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        err_len_next = err_len_reg;
        case (state_reg)
            LOAD_A, LOAD_B: begin
                if (xfer) begin
                    if (early_last) begin
                        state_next   = LOAD_A;
                        idx_next     = '0;
                        err_len_next = 1'b1;
                    end else if (last_pos) begin
                        idx_next   = '0;
                        state_next = (state_reg == LOAD_A) ? LOAD_B : PRESENT;
                        if (state_reg == LOAD_B && !bus.in_last) begin
                            err_len_next = 1'b1;
                        end
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    state_next = LOAD_A;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = LOAD_A;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            state_reg   <= LOAD_A;
            idx_reg     <= '0;
            err_len_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            err_len_reg <= err_len_next;
        end
    end

    mmac_elem_packer #(.N_ELEMS(N_ELEMS), .VAR_WIDTH(VAR_WIDTH), .IDX_W(IDX_W)) u_pack_a (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .we    (we_a),
        .slot  (idx_reg),
        .data  (bus.in_data),
        .mat   (mat_a)
    );

    mmac_elem_packer #(.N_ELEMS(N_ELEMS), .VAR_WIDTH(VAR_WIDTH), .IDX_W(IDX_W)) u_pack_b (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .we    (we_b),
        .slot  (b_slot),
        .data  (bus.in_data),
        .mat   (mat_b)
    );

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state_reg == PRESENT);
    assign bus.matrix_a  = mat_a;
    assign bus.matrix_b  = mat_b;
    assign err_len       = err_len_reg;
endmodule

// File: tb/tb_mmac_operand_loader.sv
// Scoreboard bench for mmac_operand_loader: expected pairs queued at stimulus, popped on pair handshake.
module tb_mmac_operand_loader;
    import mmac_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    logic err_len;

    always #5 clock = ~clock;

    mmac_operand_loader_if #(.VAR_WIDTH(VAR_WIDTH), .MAT_WIDTH(MAT_WIDTH)) bus ();

    mmac_operand_loader dut (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .bus     (bus),
        .err_len (err_len)
    );

    typedef struct packed {
        logic [MAT_WIDTH-1:0] a;
        logic [MAT_WIDTH-1:0] b;
    } pair_t;

    pair_t      exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] a_vals[16];
    logic [7:0] b_vals[16];
    pair_t      cur_exp;

    task automatic check_eq(input string tag, input logic [MAT_WIDTH-1:0] obs, input logic [MAT_WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference packing: A row-major; B row- or column-major stream order.
    function automatic pair_t pack_pair();
        pair_t p;
        int    r, c;
        p = '0;
        for (int i = 0; i < N_ELEMS; i++) begin
            p.a[slot_lsb(i / M_SIZE, i % M_SIZE) +: 8] = a_vals[i];
`ifdef MMAC_LOADER_TRANSPOSE_B_EN
            r = i % M_SIZE;
            c = i / M_SIZE;
`else
            r = i / M_SIZE;
            c = i % M_SIZE;
`endif
            p.b[slot_lsb(r, c) +: 8] = b_vals[i];
        end
        return p;
    endfunction

    always @(negedge clock) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pair", {127'b0, bus.out_valid}, '0);
            end else begin
                pair_t e;
                e = exp_q.pop_front();
                check_eq("pair_a", bus.matrix_a, e.a);
                check_eq("pair_b", bus.matrix_b, e.b);
                $display("pair accepted a=%h b=%h", bus.matrix_a, bus.matrix_b);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the element.
    task automatic send_elem(input logic [7:0] d, input logic last);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clock);
        while (!bus.in_ready && guard < 200) begin
            @(posedge clock); #1;
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) check_eq("in_ready_timeout", {127'b0, bus.in_ready}, 1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit tag_last, input int last_at);
        if (last_at == 2 * N_ELEMS - 1) exp_q.push_back(pack_pair());
        for (int i = 0; i < 2 * N_ELEMS; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom);
                    @(posedge clock); #1;
                end
            end
            send_elem(i < N_ELEMS ? a_vals[i] : b_vals[i - N_ELEMS], tag_last && (i == last_at));
            if (i == last_at) break;
        end
    endtask

    task automatic finish_pair();
        @(negedge clock);
        check_eq("out_valid_rise", {127'b0, bus.out_valid}, 1);
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("out_valid_drop", {127'b0, bus.out_valid}, 0);
        check_eq("in_ready_after", {127'b0, bus.in_ready}, 1);
        @(posedge clock); #1;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < N_ELEMS; i++) begin
            a_vals[i] = 8'(i + 1);
            b_vals[i] = 8'(i + 17);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_in_ready", {127'b0, bus.in_ready}, 0);
        check_eq("rst_out_valid", {127'b0, bus.out_valid}, 0);
        check_eq("rst_matrix_a", bus.matrix_a, 0);
        check_eq("rst_matrix_b", bus.matrix_b, 0);
        check_eq("rst_err_len", {127'b0, err_len}, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Case 1: ramp frame, sink always ready.
        set_ramp();
        bus.out_ready = 1'b1;
        send_frame(0, 1, 31);
        @(negedge clock);
        check_eq("c1_out_valid", {127'b0, bus.out_valid}, 1);
        check_eq("c1_in_ready", {127'b0, bus.in_ready}, 0);
        check_eq("c1_a_msb", {120'b0, bus.matrix_a[127:120]}, 1);
        check_eq("c1_a_lsb", {120'b0, bus.matrix_a[7:0]}, 16);
        check_eq("c1_b_msb", {120'b0, bus.matrix_b[127:120]}, 17);
        check_eq("c1_err_len", {127'b0, err_len}, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("c1_out_valid_1cyc", {127'b0, bus.out_valid}, 0);
        check_eq("c1_in_ready_next", {127'b0, bus.in_ready}, 1);
        @(posedge clock); #1;

        // Case 2: backpressure for 5 cycles.
        bus.out_ready = 1'b0;
        cur_exp = pack_pair();
        send_frame(0, 1, 31);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_eq("c2_out_valid_hold", {127'b0, bus.out_valid}, 1);
            check_eq("c2_in_ready_low", {127'b0, bus.in_ready}, 0);
            check_eq("c2_a_stable", bus.matrix_a, cur_exp.a);
            check_eq("c2_b_stable", bus.matrix_b, cur_exp.b);
            @(posedge clock); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        check_eq("c2_out_valid_6th", {127'b0, bus.out_valid}, 1);
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("c2_in_ready_after", {127'b0, bus.in_ready}, 1);
        check_eq("c2_out_valid_drop", {127'b0, bus.out_valid}, 0);
        @(posedge clock); #1;

        // Case 3: random valid gaps with junk data on idle cycles.
        send_frame(1, 1, 31);
        finish_pair();

        // Case 4: in_last on element 10 truncates the frame.
        send_frame(0, 1, 9);
        @(negedge clock);
        check_eq("c4_err_len", {127'b0, err_len}, 1);
        check_eq("c4_no_out_valid", {127'b0, bus.out_valid}, 0);
        check_eq("c4_in_ready", {127'b0, bus.in_ready}, 1);
        @(posedge clock); #1;
        for (int i = 0; i < N_ELEMS; i++) begin
            a_vals[i] = 8'(100 + 3 * i);
            b_vals[i] = 8'(200 - 5 * i);
        end
        send_frame(0, 1, 31);
        finish_pair();
        check_eq("c4_err_sticky", {127'b0, err_len}, 1);

        // Case 5: clear mid-B, colliding with a valid element.
        set_ramp();
        send_frame(0, 0, 19);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        clear        = 1'b1;
        @(posedge clock); #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check_eq("c5_matrix_a_zero", bus.matrix_a, 0);
        check_eq("c5_matrix_b_zero", bus.matrix_b, 0);
        check_eq("c5_err_len", {127'b0, err_len}, 0);
        check_eq("c5_out_valid", {127'b0, bus.out_valid}, 0);
        check_eq("c5_in_ready", {127'b0, bus.in_ready}, 1);
        @(posedge clock); #1;
        for (int i = 0; i < N_ELEMS; i++) begin
            a_vals[i] = 8'hFF;
            b_vals[i] = 8'hFF;
        end
        send_frame(0, 1, 31);
        @(negedge clock);
        check_eq("c5_all_ones_a", bus.matrix_a, {MAT_WIDTH{1'b1}});
        check_eq("c5_all_ones_b", bus.matrix_b, {MAT_WIDTH{1'b1}});
        @(posedge clock); #1;
        @(negedge clock);
        @(posedge clock); #1;

        // Case 6: B stream order determines placement of (1,0) and (0,1).
        set_ramp();
        bus.out_ready = 1'b0;
        send_frame(0, 1, 31);
        @(negedge clock);
`ifdef MMAC_LOADER_TRANSPOSE_B_EN
        check_eq("c6_b_r1c0", {120'b0, bus.matrix_b[slot_lsb(1, 0) +: 8]}, 18);
        check_eq("c6_b_r0c1", {120'b0, bus.matrix_b[slot_lsb(0, 1) +: 8]}, 21);
`else
        check_eq("c6_b_r1c0", {120'b0, bus.matrix_b[slot_lsb(1, 0) +: 8]}, 21);
        check_eq("c6_b_r0c1", {120'b0, bus.matrix_b[slot_lsb(0, 1) +: 8]}, 18);
`endif
        check_eq("c6_a_r1c0", {120'b0, bus.matrix_a[slot_lsb(1, 0) +: 8]}, 5);
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        finish_pair();

        // Case 7: full-length frame without in_last is accepted but flagged.
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        send_frame(0, 0, 31);
        finish_pair();
        check_eq("c7_err_len_missing_last", {127'b0, err_len}, 1);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
